// File: rtl/card_pkg.sv
// card_pkg: shared types and constants for the card slot scheduler.
//   card_slot_t     - one slot descriptor {visible, x_pin, y_pin, digit, color}
//   commit_state_e  - shadow-to-active commit FSM states
//   COL_*           - renderer colour codes
//   SPRITE_*_DEF    - default inclusive box extents
package card_pkg;

  localparam int SPRITE_W_DEF = 30;
  localparam int SPRITE_H_DEF = 50;

  localparam logic [1:0] COL_RED = 2'b00;
  localparam logic [1:0] COL_YEL = 2'b01;
  localparam logic [1:0] COL_GRN = 2'b10;
  localparam logic [1:0] COL_BLU = 2'b11;

  typedef struct packed {
    logic       visible;
    logic [9:0] x_pin;
    logic [9:0] y_pin;
    logic [3:0] digit;
    logic [1:0] color;
  } card_slot_t;

  localparam card_slot_t SLOT_EMPTY = '0;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } commit_state_e;

endpackage

// File: rtl/card_slot_hit.sv
// card_slot_hit: combinational box test for one slot.
//   slot_i - slot descriptor from the active table
//   mask_i - force the slot invisible (blink OFF phase)
//   x_i    - current scan x
//   y_i    - current scan y
//   hit_o  - slot is visible and covers (x_i, y_i)
module card_slot_hit
  import card_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEF,
  parameter int SPRITE_H = SPRITE_H_DEF
) (
  input  card_slot_t slot_i,
  input  logic       mask_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       hit_o
);

  // Far edges are computed at 11 bits so a box near 1023 clips instead of wrapping.
  logic [10:0] x_end;
  logic [10:0] y_end;

  assign x_end = {1'b0, slot_i.x_pin} + 11'(SPRITE_W);
  assign y_end = {1'b0, slot_i.y_pin} + 11'(SPRITE_H);

  assign hit_o = slot_i.visible && !mask_i
              && (x_i >= slot_i.x_pin) && ({1'b0, x_i} <= x_end)
              && (y_i >= slot_i.y_pin) && ({1'b0, y_i} <= y_end);

endmodule

// File: rtl/card_slot_scheduler.sv
// card_slot_scheduler: time-shares one card-glyph renderer between NUM_SLOTS cards.
//   clk, rst            - pixel clock, synchronous active-high reset
//   x_cnt, y_cnt        - current scan position
//   frame_start         - one-cycle pulse per frame (vertical blank)
//   wr_en, wr_slot, wr_*- descriptor write into the shadow table
//   commit              - request shadow->active copy at the next frame_start
//   blink_en, blink_slot- blink one slot at BLINK_FRAMES frames per half-period
//   commit_pending      - commit requested, copy not yet done
//   sel_*               - winning (highest-index) covering slot, 2 cycles after x/y
module card_slot_scheduler
  import card_pkg::*;
#(
  parameter int NUM_SLOTS    = 8,
  parameter int SPRITE_W     = SPRITE_W_DEF,
  parameter int SPRITE_H     = SPRITE_H_DEF,
  parameter int BLINK_FRAMES = 15,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    x_cnt,
  input  logic [9:0]    y_cnt,
  input  logic          frame_start,
  input  logic          wr_en,
  input  logic [SW-1:0] wr_slot,
  input  logic          wr_visible,
  input  logic [9:0]    wr_x_pin,
  input  logic [9:0]    wr_y_pin,
  input  logic [3:0]    wr_digit,
  input  logic [1:0]    wr_color,
  input  logic          commit,
  input  logic          blink_en,
  input  logic [SW-1:0] blink_slot,
  output logic          commit_pending,
  output logic          sel_valid,
  output logic [SW-1:0] sel_slot,
  output logic [9:0]    sel_x_pin,
  output logic [9:0]    sel_y_pin,
  output logic [3:0]    sel_digit,
  output logic [1:0]    sel_color
);

  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  card_slot_t    shadow_q [NUM_SLOTS];
  card_slot_t    active_q [NUM_SLOTS];
  commit_state_e state_q;

  // Tables are read in parallel by every hit tester, so they live in flops.
  // The swap copies the shadow value from before this cycle's write, so a
  // write landing in the swap cycle stays in the shadow table only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow_q[i] <= SLOT_EMPTY;
        active_q[i] <= SLOT_EMPTY;
      end
    end else begin
      if (wr_en) begin
        shadow_q[wr_slot] <= '{visible: wr_visible, x_pin: wr_x_pin, y_pin: wr_y_pin,
                               digit: wr_digit, color: wr_color};
      end
      case (state_q)
        ST_IDLE: begin
          if (commit) begin
            if (frame_start) active_q <= shadow_q;
            else             state_q  <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (frame_start) begin
            active_q <= shadow_q;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign commit_pending = (state_q == ST_PENDING);

  // Blink: counter and phase only run while blink_en is high.
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (!blink_en) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (frame_start) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  logic blink_off;
  assign blink_off = blink_en && !blink_on_q;

  // S1: per-slot hit vector.
  logic [NUM_SLOTS-1:0] slot_mask;
  logic [NUM_SLOTS-1:0] hit_d;
  logic [NUM_SLOTS-1:0] hit_q;

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign slot_mask[gi] = blink_off && (blink_slot == SW'(gi));
    card_slot_hit #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H)
    ) u_hit (
      .slot_i (active_q[gi]),
      .mask_i (slot_mask[gi]),
      .x_i    (x_cnt),
      .y_i    (y_cnt),
      .hit_o  (hit_d[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) hit_q <= '0;
    else     hit_q <= hit_d;
  end

  // S2: highest hit index wins (later iterations override earlier ones).
  logic          win_valid;
  logic [SW-1:0] win_idx;
  card_slot_t    win_slot;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (hit_q[i]) begin
        win_valid = 1'b1;
        win_idx   = SW'(i);
      end
    end
    win_slot = active_q[win_idx];
  end

  always_ff @(posedge clk) begin
    if (rst || !win_valid) begin
      sel_valid <= 1'b0;
      sel_slot  <= '0;
      sel_x_pin <= '0;
      sel_y_pin <= '0;
      sel_digit <= '0;
      sel_color <= '0;
    end else begin
      sel_valid <= 1'b1;
      sel_slot  <= win_idx;
      sel_x_pin <= win_slot.x_pin;
      sel_y_pin <= win_slot.y_pin;
      sel_digit <= win_slot.digit;
      sel_color <= win_slot.color;
    end
  end

endmodule

// File: tb/tb_card_slot_scheduler.sv
module tb_card_slot_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] x_cnt = '0;
  logic [9:0] y_cnt = '0;
  logic       frame_start = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_slot = '0;
  logic       wr_visible = 1'b0;
  logic [9:0] wr_x_pin = '0;
  logic [9:0] wr_y_pin = '0;
  logic [3:0] wr_digit = '0;
  logic [1:0] wr_color = '0;
  logic       commit = 1'b0;
  logic       blink_en = 1'b0;
  logic [2:0] blink_slot = '0;
  logic       commit_pending;
  logic       sel_valid;
  logic [2:0] sel_slot;
  logic [9:0] sel_x_pin;
  logic [9:0] sel_y_pin;
  logic [3:0] sel_digit;
  logic [1:0] sel_color;

  always #5 clk = ~clk;

  card_slot_scheduler #(
    .NUM_SLOTS    (8),
    .SPRITE_W     (30),
    .SPRITE_H     (50),
    .BLINK_FRAMES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .x_cnt          (x_cnt),
    .y_cnt          (y_cnt),
    .frame_start    (frame_start),
    .wr_en          (wr_en),
    .wr_slot        (wr_slot),
    .wr_visible     (wr_visible),
    .wr_x_pin       (wr_x_pin),
    .wr_y_pin       (wr_y_pin),
    .wr_digit       (wr_digit),
    .wr_color       (wr_color),
    .commit         (commit),
    .blink_en       (blink_en),
    .blink_slot     (blink_slot),
    .commit_pending (commit_pending),
    .sel_valid      (sel_valid),
    .sel_slot       (sel_slot),
    .sel_x_pin      (sel_x_pin),
    .sel_y_pin      (sel_y_pin),
    .sel_digit      (sel_digit),
    .sel_color      (sel_color)
  );

  typedef struct packed {
    logic       v;
    logic [2:0] s;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] d;
    logic [1:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   id_q[$];
  int   checks = 0;
  int   errors = 0;
  int   probe_id = 0;

  // Probe markers travel alongside the DUT pipeline: an entry is due exactly
  // two clock edges after its x/y were presented.
  logic probe_flag = 1'b0;
  logic pd1 = 1'b0;
  logic pd2 = 1'b0;

  always @(posedge clk) begin
    pd1 <= probe_flag;
    pd2 <= pd1;
  end

  exp_t mon_e;
  exp_t mon_a;
  int   mon_id;

  always @(negedge clk) begin
    if (pd2) begin
      mon_a = {sel_valid, sel_slot, sel_x_pin, sel_y_pin, sel_digit, sel_color};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pix_underflow: output present v=%0b with no expected entry", mon_a.v);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_id = id_q.pop_front();
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL pix%0d: got v=%0b s=%0d x=%0d y=%0d d=%0d c=%0d expected v=%0b s=%0d x=%0d y=%0d d=%0d c=%0d",
                   mon_id, mon_a.v, mon_a.s, mon_a.x, mon_a.y, mon_a.d, mon_a.c,
                   mon_e.v, mon_e.s, mon_e.x, mon_e.y, mon_e.d, mon_e.c);
        end else begin
          $display("pix%0d ok v=%0b s=%0d x=%0d y=%0d d=%0d c=%0d",
                   mon_id, mon_a.v, mon_a.s, mon_a.x, mon_a.y, mon_a.d, mon_a.c);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    wr_en       = 1'b0;
    commit      = 1'b0;
    frame_start = 1'b0;
    probe_flag  = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic probe(input int x, input int y, input logic v, input int s,
                       input int xp, input int yp, input int d, input int c);
    step();
    x_cnt      = 10'(x);
    y_cnt      = 10'(y);
    probe_flag = 1'b1;
    exp_q.push_back({v, 3'(s), 10'(xp), 10'(yp), 4'(d), 2'(c)});
    id_q.push_back(probe_id);
    probe_id++;
  endtask

  task automatic probe_none(input int x, input int y);
    probe(x, y, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic write_slot(input int s, input logic vis, input int x, input int y,
                            input int d, input int c);
    step();
    wr_en      = 1'b1;
    wr_slot    = 3'(s);
    wr_visible = vis;
    wr_x_pin   = 10'(x);
    wr_y_pin   = 10'(y);
    wr_digit   = 4'(d);
    wr_color   = 2'(c);
  endtask

  task automatic do_commit();
    step();
    commit = 1'b1;
  endtask

  task automatic pulse_fs();
    step();
    frame_start = 1'b1;
  endtask

  task automatic chk_pend(input logic exp, input string name);
    checks++;
    if (commit_pending !== exp) begin
      errors++;
      $display("FAIL %s: commit_pending got %0b expected %0b", name, commit_pending, exp);
    end else begin
      $display("%s ok commit_pending=%0b", name, commit_pending);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. reset
    repeat (3) begin
      step();
      rst = 1'b1;
    end
    step();
    chk_pend(1'b0, "rst_pend");
    probe_none(500, 300);
    probe_none(0, 0);

    // 2. slot2 at (100,40), committed
    write_slot(2, 1'b1, 100, 40, 4, 1);
    do_commit();
    step();
    chk_pend(1'b1, "commit_pend_set");
    pulse_fs();
    step();
    chk_pend(1'b0, "commit_pend_clear");
    probe(100, 40, 1'b1, 2, 100, 40, 4, 1);
    probe(130, 90, 1'b1, 2, 100, 40, 4, 1);
    probe_none(131, 90);
    probe_none(130, 91);
    probe_none(99, 40);

    // 3. shadow write without commit is not visible
    write_slot(2, 1'b1, 300, 200, 7, 2);
    pulse_fs();
    step();
    chk_pend(1'b0, "nocommit_pend");
    probe_none(300, 200);
    probe(100, 40, 1'b1, 2, 100, 40, 4, 1);

    // 4. overlap priority and blink masking
    write_slot(1, 1'b1, 100, 40, 9, 3);
    write_slot(5, 1'b1, 110, 40, 6, 2);
    do_commit();
    pulse_fs();
    probe(115, 50, 1'b1, 5, 110, 40, 6, 2);
    probe(105, 50, 1'b1, 1, 100, 40, 9, 3);
    probe(300, 200, 1'b1, 2, 300, 200, 7, 2);
    step();
    blink_en   = 1'b1;
    blink_slot = 3'd5;
    pulse_fs();
    probe(115, 50, 1'b1, 5, 110, 40, 6, 2);
    pulse_fs();
    probe(115, 50, 1'b1, 1, 100, 40, 9, 3);
    probe_none(140, 90);
    step();
    blink_en = 1'b0;
    probe(115, 50, 1'b1, 5, 110, 40, 6, 2);

    // 5. commit and frame_start together, with a write in the same cycle
    write_slot(3, 1'b1, 600, 400, 2, 0);
    step();
    commit      = 1'b1;
    frame_start = 1'b1;
    wr_en       = 1'b1;
    wr_slot     = 3'd3;
    wr_visible  = 1'b1;
    wr_x_pin    = 10'd700;
    wr_y_pin    = 10'd500;
    wr_digit    = 4'd8;
    wr_color    = 2'd1;
    step();
    chk_pend(1'b0, "same_cycle_pend");
    probe(600, 400, 1'b1, 3, 600, 400, 2, 0);
    probe_none(700, 500);
    do_commit();
    pulse_fs();
    probe(700, 500, 1'b1, 3, 700, 500, 8, 1);
    probe_none(600, 400);

    // commit while pending has no effect
    do_commit();
    step();
    chk_pend(1'b1, "pend_first");
    do_commit();
    step();
    chk_pend(1'b1, "pend_second");
    pulse_fs();
    step();
    chk_pend(1'b0, "pend_done");

    // 6. blink slot2 with 2 frames per half-period
    step();
    blink_en   = 1'b1;
    blink_slot = 3'd2;
    probe(300, 200, 1'b1, 2, 300, 200, 7, 2);
    for (int k = 1; k <= 8; k++) begin
      pulse_fs();
      if (((k / 2) % 2) == 0) probe(300, 200, 1'b1, 2, 300, 200, 7, 2);
      else                    probe_none(300, 200);
    end

    // reset mid-frame: in-flight pixel and reset-cycle pixel both read 0
    probe_none(300, 200);
    probe_none(300, 200);
    rst = 1'b1;
    step();
    blink_en = 1'b0;
    probe_none(300, 200);
    probe_none(115, 50);
    probe_none(700, 500);
    chk_pend(1'b0, "post_rst_pend");
    do_commit();
    pulse_fs();
    probe_none(100, 40);
    probe_none(300, 200);

    repeat (5) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
